// File: rtl/joy_pad_resp.sv
// Console joypad responder: returns plain joystick bits or a row-scanned keypad
// row on P_IN, with the scan row advanced by synchronized OUT1/OUT0 strobe edges.
module joy_pad_resp #(
  parameter int TIMEOUT = 4096,
  parameter int ROWS    = 5
) (
  input  logic              CLK_24M,
  input  logic              RESET,
  input  logic [2:0]        P_OUT,
  input  logic              MODE_SCAN,
  input  logic [9:0]        JOY,
  input  logic [8*ROWS-1:0] KEYS,
  output logic [9:0]        P_IN,
  output logic [2:0]        ROW,
  output logic              SCAN_ACT
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [2:0]      ROW_LAST = 3'(ROWS - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_nxt;
  logic [2:0]     s1, s2;
  logic [1:0]     s3, armed;
  logic           v1, v2;
  logic           rise1, rise0;
  logic [2:0]     row_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [7:0]     key_row;
  logic [9:0]     p_in_nxt;

  // OUT2 is only used as a level, so edge detection is kept for OUT1/OUT0.
  // v1/v2 mark when s2 holds a real sample, so a strobe that is already high
  // at reset release is ignored until it has been seen low once.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= '0;
    end else begin
      s1    <= P_OUT;
      s2    <= s1;
      s3    <= s2[1:0];
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | ({2{v2}} & ~s2[1:0]);
    end
  end

  assign rise1 = s2[1] & ~s3[1] & armed[1];
  assign rise0 = s2[0] & ~s3[0] & armed[0];

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state <= IDLE;
      ROW   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ROW   <= row_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leaving SCAN (mode change or timeout) outranks strobes; OUT1 outranks OUT0.
  always_comb begin
    state_nxt = state;
    row_nxt   = ROW;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        row_nxt = '0;
        cnt_nxt = '0;
        if (MODE_SCAN && (rise1 || rise0))
          state_nxt = SCAN;
      end
      SCAN: begin
        if (!MODE_SCAN || cnt == CNT_MAX) begin
          state_nxt = IDLE;
          row_nxt   = '0;
          cnt_nxt   = '0;
        end else if (rise1) begin
          row_nxt = '0;
          cnt_nxt = '0;
        end else if (rise0) begin
          row_nxt = (ROW == ROW_LAST) ? 3'd0 : ROW + 3'd1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SCAN_ACT = (state == SCAN);
    key_row  = '0;
    for (int r = 0; r < ROWS; r++)
      if (ROW == 3'(r))
        key_row = KEYS[8*r +: 8];
    if (s2[2])
      p_in_nxt = 10'h3FF;
    else if (!MODE_SCAN)
      p_in_nxt = ~JOY;
    else if (state == SCAN)
      p_in_nxt = {2'b11, ~key_row};
    else
      p_in_nxt = 10'h3FF;
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET)
      P_IN <= 10'h3FF;
    else
      P_IN <= p_in_nxt;
  end

endmodule

// File: doc/joy_pad_resp.md
JOY_PAD_RESP -- requirements
Module: joy_pad_resp

Interface
REQ-001 Parameter TIMEOUT, default 4096, SHALL set the clock count without an OUT0 strobe after which the scan state returns to IDLE.
REQ-002 Parameter ROWS, default 5, SHALL set the number of scanned key rows; the legal range is 2..8.
REQ-003 CLK_24M  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be a synchronous, active-high reset sampled on the CLK_24M rising edge.
REQ-005 P_OUT  input  3  SHALL carry the console port output strobes OUT2..OUT0; asynchronous to CLK_24M.
REQ-006 MODE_SCAN  input  1  SHALL select the mode: 0 = plain joystick, 1 = row-scanned keypad; quasi-static.
REQ-007 JOY  input  10  SHALL carry the plain-mode inputs {B4..B1, Right, Left, Down, Up} in bits 7:0 and {Select, Start} in bits 9:8; active-high pressed.
REQ-008 KEYS  input  8*ROWS  SHALL carry the key matrix; row r is KEYS[8r+7:8r]; active-high pressed.
REQ-009 P_IN  output  10  SHALL carry the registered, active-low port inputs returned to the console.
REQ-010 ROW  output  3  SHALL carry the current scan row index, for debug.
REQ-011 SCAN_ACT  output  1  SHALL be high while the FSM is in SCAN.

Function
REQ-012 Each P_OUT bit SHALL pass through a 2-FF synchronizer (s1, s2), followed by a third register s3 used for edge detection.
REQ-013 A rise on OUTn SHALL be detected in the cycle where s2=1 and s3=0; this is one pulse per edge.
REQ-014 FSM states SHALL be IDLE and SCAN.
REQ-015 IDLE SHALL go to SCAN on an OUT1 rise or an OUT0 rise, only when MODE_SCAN=1.
REQ-016 SCAN SHALL go to IDLE on a timeout or when MODE_SCAN=0.
REQ-017 An OUT1 rise SHALL set ROW to 0 and clear the timeout counter.
REQ-018 An OUT0 rise without an OUT1 rise SHALL increment ROW, wrapping from ROWS-1 to 0, and SHALL clear the timeout counter.
REQ-019 If OUT1 and OUT0 rises occur in the same cycle, OUT1 SHALL win: ROW becomes 0 with no increment.
REQ-020 An OUT0 rise seen in IDLE SHALL enter SCAN with ROW=0 and no increment.
REQ-021 The timeout counter SHALL count only in SCAN, sized $clog2(TIMEOUT+1) bits, and saturate at TIMEOUT.
REQ-022 When the timeout counter reaches TIMEOUT, the next cycle SHALL set the state to IDLE, ROW to 0 and the counter to 0.
REQ-023 The next P_IN value SHALL be all ones (no keys) whenever synced OUT2 (s2) is 1; this overrides every mode.
REQ-024 Otherwise, with MODE_SCAN=0, the next P_IN SHALL be ~JOY.
REQ-025 Otherwise, with MODE_SCAN=1 in SCAN, the next P_IN SHALL be {2'b11, ~KEYS row ROW}.
REQ-026 Otherwise, with MODE_SCAN=1 in IDLE, the next P_IN SHALL be 10'h3FF.
REQ-027 P_IN SHALL be registered from the ROW value already updated, so an OUTn edge reaches P_IN exactly 4 clocks after the first clock that samples the new P_OUT level (s1 +1, s2 +2, ROW +3, P_IN +4).
REQ-028 JOY and KEYS SHALL be sampled without synchronization, since the bench drives them synchronously.
REQ-029 ROW SHALL never hold a value of ROWS or above.

Reset
REQ-030 While RESET=1, s1, s2 and s3 SHALL be 0, the state IDLE, ROW 0, the timeout counter 0, P_IN 10'h3FF and SCAN_ACT 0.
REQ-031 RESET asserted mid-scan SHALL take priority over every edge event in the same cycle.
REQ-032 After RESET deasserts, a P_OUT bit already high SHALL NOT produce a rise until it has been low for at least one synchronized sample.

Verification
REQ-033 Scenario 1: with MODE_SCAN=0 and JOY=10'h021, hold 6 clocks -> P_IN=10'h3DE, SCAN_ACT=0.
REQ-034 Scenario 2: with MODE_SCAN=1, KEYS row0=8'h01 and row2=8'h80, pulse OUT1, then pulse OUT0 twice, 8 clocks apart -> ROW=2, and P_IN=10'h37F 4 clocks after the second OUT0 first sample.
REQ-035 Scenario 3: with ROWS=5, five OUT0 pulses after OUT1 -> ROW sequence 1,2,3,4,0.
REQ-036 Scenario 4: raise OUT1 and OUT0 on the same clock while in SCAN at ROW=3 -> ROW=0, with no increment.
REQ-037 Scenario 5: set TIMEOUT=16, enter SCAN, then no strobes -> SCAN_ACT falls and ROW=0 at 16 clocks +1 after the last edge, and P_IN=10'h3FF the following clock.
REQ-038 Scenario 6: set OUT2=1 with keys pressed in both modes -> P_IN=10'h3FF; assert RESET at ROW=3 during an OUT0 edge -> ROW=0 and the state IDLE on the next clock.
